wide_add_seq: RTL
=================

# wide_add_seq

Multi-precision add sequencer that drives one shared 32-bit `adder` over several cycles to produce a WORDS×32-bit sum. It accepts wide operands through a valid/ready handshake and feeds one 32-bit word per cycle into the external adder, least significant word first. Each word's carry-out is chained into the next word's carry-in. The finished result is held behind a second valid/ready handshake. It sits between a wide-operand producer (e.g. display/test logic driven from the touchscreen) and the single adder instance.

## Interface
Parameters:
- WORDS, 4: number of 32-bit words per operand; legal range 2..8.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start_valid  in  1  producer presents a new operation
- start_ready  out  1  block can accept an operation
- op_a  in  32*WORDS  operand A; word k is bits [32k+31:32k]
- op_b  in  32*WORDS  operand B
- op_cin  in  1  carry into word 0 (add mode)
- op_sub  in  1  subtract request; present only with WIDE_ADD_SUB_EN
- add_operand1  out  32  to adder operand1
- add_operand2  out  32  to adder operand2
- add_cin  out  1  to adder cin
- add_result  in  32  from adder result (combinational)
- add_cout  in  1  from adder cout
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  32*WORDS  wide sum
- res_cout  out  1  final carry out of word WORDS-1
- busy  out  1  high in RUN or DONE

## Operation
State machine with three states:
- IDLE:
  - start_ready=1.
  - On start_valid: latch op_a and op_b, set carry←op_cin, set beat←0, go to RUN.
- RUN:
  - Drive add_operand1=A[beat], add_operand2=B[beat], add_cin=carry.
  - At each edge: result[beat]←add_result, carry←add_cout, beat←beat+1.
  - When beat==WORDS-1, go to DONE instead of incrementing.
- DONE:
  - res_valid=1; res_cout=carry.
  - result and res_cout stay stable until res_ready is sampled high, then go to IDLE.

Rules:
- start_ready=0 in RUN and DONE; start_valid is ignored there and the latched operands never change mid-operation.
- In IDLE and DONE, add_operand1, add_operand2 and add_cin are driven to 0.
- beat is a 3-bit counter; it never exceeds WORDS-1 and never wraps.
- Arithmetic is modulo 2^(32*WORDS); overflow is not flagged. res_cout is the only extra output bit.
- The adder is assumed combinational with a single-cycle path; there is no wait state.

Reset (resetn=0 at an edge) returns the block to IDLE from any state and aborts an in-flight operation with no result. Values after reset:
- state IDLE, beat 0, carry 0, result 0, res_cout 0
- res_valid 0, start_ready 1, busy 0
- add_* outputs 0

## Timing
- Acceptance edge T is the first edge with start_valid=1 in IDLE. RUN occupies edges T+1..T+WORDS.
- res_valid rises after edge T+WORDS, i.e. WORDS cycles after acceptance.
- If res_valid and res_ready are both high at edge D, the block is in IDLE after D. The earliest next acceptance is edge D+1. Throughput is therefore one operation per WORDS+2 cycles.
- res_ready held high in advance: DONE lasts exactly one cycle.
- start_valid held high continuously: a new operation is accepted on the first IDLE edge, and the operand values sampled are those present at that edge.
- No combinational path from start_valid to start_ready, or from res_ready to res_valid. Both are functions of state only.

## Configuration
Macro WIDE_ADD_SUB_EN:
- Defined: the op_sub port exists and is latched at acceptance. When op_sub=1, every add_operand2 word is ~B[beat], the initial carry is forced to 1 (op_cin is ignored), and the result is A−B. res_cout=1 means no borrow (A≥B unsigned).
- Undefined: the op_sub port is absent and the block performs A+B+op_cin only.

## Test plan
All scenarios use WORDS=4.
- Reset then idle: after reset, start_ready=1, res_valid=0, result=0, and add_operand1, add_operand2 and add_cin are all 0.
- Carry ripple:
  - Stimulus: A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, cin=0.
  - Response: result=0x00000001_00000000_00000000_00000000, res_cout=0, res_valid rises 4 cycles after acceptance.
- Full overflow:
  - Stimulus: A=all ones, B=0, cin=1.
  - Response: result=0 and res_cout=1.
- Back-pressure:
  - Stimulus: hold res_ready=0 for 10 cycles while pulsing start_valid with different operands.
  - Response: result stays stable, start_ready stays 0, and the second operation is accepted only on the first edge after the handshake.
- Reset mid-RUN:
  - Stimulus: assert resetn=0 at beat 2.
  - Response: block is in IDLE the next cycle, res_valid never rises, and result=0.
- WIDE_ADD_SUB_EN:
  - Stimulus 1: A=5, B=7, sub=1. Response: result=0xFFFF…FFFE, res_cout=0.
  - Stimulus 2: A=7, B=5, sub=1. Response: result=2, res_cout=1.

Source files
------------

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Purpose  : Multi-precision add sequencer. Streams WORDS x 32-bit operands
//            LSW first through one shared external 32-bit adder, chaining the
//            carry, and holds the wide sum behind a valid/ready handshake.
//            Optional macro WIDE_ADD_SUB_EN adds an op_sub port (A-B mode).
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    input  logic                  op_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  op_sub,
`endif
    output logic [31:0]           add_operand1,
    output logic [31:0]           add_operand2,
    output logic                  add_cin,
    input  logic [31:0]           add_result,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [32*WORDS-1:0]   result,
    output logic                  res_cout,
    output logic                  busy
);

    // Word index width: the 3-bit beat counter is narrowed to address the word arrays.
    localparam int         c_IW   = (WORDS <= 2) ? 1 : ((WORDS <= 4) ? 2 : 3);
    localparam logic [2:0] c_LAST = 3'(WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [2:0]      r_beat;
    logic            r_carry;
    logic [31:0]     r_a   [WORDS];
    logic [31:0]     r_b   [WORDS];
    logic [31:0]     r_res [WORDS];

    logic [c_IW-1:0] w_idx;
    logic            w_run;
    logic [31:0]     w_b_word;
    logic            w_init_carry;

    assign w_idx = r_beat[c_IW-1:0];
    assign w_run = (r_state == c_RUN);

`ifdef WIDE_ADD_SUB_EN
    logic            r_sub;

    // Subtraction is A + ~B + 1; the forced carry supplies the +1.
    assign w_b_word     = r_b[w_idx] ^ {32{r_sub}};
    assign w_init_carry = op_sub ? 1'b1 : op_cin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sub <= 1'b0;
        end else if (r_state == c_IDLE && start_valid) begin
            r_sub <= op_sub;
        end
    end
`else
    assign w_b_word     = r_b[w_idx];
    assign w_init_carry = op_cin;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_beat  <= 3'd0;
            r_carry <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_a[k]   <= 32'd0;
                r_b[k]   <= 32'd0;
                r_res[k] <= 32'd0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_valid) begin
                        for (int k = 0; k < WORDS; k++) begin
                            r_a[k] <= op_a[32*k +: 32];
                            r_b[k] <= op_b[32*k +: 32];
                        end
                        r_carry <= w_init_carry;
                        r_beat  <= 3'd0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_res[w_idx] <= add_result;
                    r_carry      <= add_cout;
                    // Beat parks on the last word rather than wrapping.
                    if (r_beat == c_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                c_DONE: begin
                    if (res_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs depend on state only, never on the partner's strobe.
    assign start_ready  = (r_state == c_IDLE);
    assign res_valid    = (r_state == c_DONE);
    assign busy         = (r_state != c_IDLE);
    assign res_cout     = r_carry;

    assign add_operand1 = w_run ? r_a[w_idx] : 32'd0;
    assign add_operand2 = w_run ? w_b_word   : 32'd0;
    assign add_cin      = w_run & r_carry;

    generate
        for (genvar k = 0; k < WORDS; k++) begin : g_result
            assign result[32*k +: 32] = r_res[k];
        end
    endgenerate

endmodule
`default_nettype wire
